instruction_fetch: RTL

Instruction fetch stage for the RV32I multi-cycle core. Drives the read port of the unified `memory` block (one-cycle synchronous read latency), captures returned words into a 2-entry buffer, and presents them with their PC to decode over a valid/ready handshake. It also handles PC redirects from branch/jump resolution, yields the shared read port to load/store accesses, and flags misaligned redirect targets.

---
 rtl/instruction_fetch_if.sv | 43 ++++
 rtl/instruction_fetch.sv | 130 +++++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: memory read port, redirect input and decode handshake.
// The master modport is the fetch side; the slave modport is the memory/decode side.
interface instruction_fetch_if;
    logic [31:0] mem_read_address;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_read_data;
    logic        mem_grant;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    modport master (
        output mem_read_address,
        output mem_funct3,
        input  mem_read_data,
        input  mem_grant,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        output fetch_fault
    );

    modport slave (
        input  mem_read_address,
        input  mem_funct3,
        output mem_read_data,
        output mem_grant,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: issues word reads to a 1-cycle-latency memory, buffers up to two
// returned words with their PCs and hands them to decode; handles redirects and faults.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instruction_fetch_if.master  bus
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        pending_reg, pending_next;
    logic [31:0] pending_pc_reg, pending_pc_next;
    logic [1:0]  count_reg, count_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic        wr_ptr_reg, wr_ptr_next;

    logic        pop;
    logic        push;
    logic        room;
    logic        issue_seq;
    logic        redirect_aligned;
    logic [31:0] head_word;
    logic [31:0] head_pc;

    assign pop              = bus.instr_valid && bus.instr_ready;
    assign redirect_aligned = (bus.redirect_pc[1:0] == 2'b00);
    // A response landing in a redirect cycle belongs to the old path and is dropped;
    // the read issued in that cycle is already the redirect target.
    assign push             = pending_reg && !bus.redirect_valid;
    assign room             = ({1'b0, count_reg} + {2'b00, pending_reg}) < 3'd2;
    assign issue_seq        = (state_reg == RUN) && bus.mem_grant && (room || pop);

    assign bus.mem_read_address = bus.redirect_valid ? bus.redirect_pc : pc_reg;
    assign bus.mem_funct3       = 3'b010;
    assign bus.instr_valid      = (count_reg != 2'd0) && (state_reg == RUN);
    assign bus.instr            = head_word;
    assign bus.instr_pc         = head_pc;
    assign bus.fetch_fault      = (state_reg == FAULT);

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pending_next    = 1'b0;
        pending_pc_next = pending_pc_reg;
        if (bus.redirect_valid) begin
            pc_next = bus.redirect_pc;
            if (redirect_aligned) begin
                state_next = RUN;
                if (bus.mem_grant) begin
                    pending_next    = 1'b1;
                    pending_pc_next = bus.redirect_pc;
                    pc_next         = bus.redirect_pc + 32'd4;
                end
            end else begin
                state_next = FAULT;
            end
        end else if (issue_seq) begin
            pending_next    = 1'b1;
            pending_pc_next = pc_reg;
            pc_next         = pc_reg + 32'd4;
        end
    end

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (bus.redirect_valid) begin
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
        end else begin
            count_next = count_reg + {1'b0, push} - {1'b0, pop};
            if (push) begin
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RUN;
            pc_reg         <= RESET_PC;
            pending_reg    <= 1'b0;
            pending_pc_reg <= 32'h0;
            count_reg      <= 2'd0;
            rd_ptr_reg     <= 1'b0;
            wr_ptr_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pending_reg    <= pending_next;
            pending_pc_reg <= pending_pc_next;
            count_reg      <= count_next;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [31:0] word_reg;
            logic [31:0] pc_entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg     <= 32'h0;
                    pc_entry_reg <= 32'h0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    word_reg     <= bus.mem_read_data;
                    pc_entry_reg <= pending_pc_reg;
                end
            end
        end
    endgenerate

    assign head_word = rd_ptr_reg ? g_fifo[1].word_reg     : g_fifo[0].word_reg;
    assign head_pc   = rd_ptr_reg ? g_fifo[1].pc_entry_reg : g_fifo[0].pc_entry_reg;

endmodule
